mstage_lsu: RTL and testbench
=============================

Name: mstage_lsu

Overview:
- Memory-access stage between the E->M pipeline register and the M->W bus register.
- Accepts one instruction per valid/ready handshake from upstream.
- For loads and stores, runs one transaction on a simple request/acknowledge data bus, then aligns and extends the load data.
- Presents the result downstream with a valid/ready handshake; the result is held stable until it is accepted.

Parameters:
- TIMEOUT, default 0: maximum number of cycles to wait for mem_ack. 0 disables the timeout. Otherwise the value is compared against a 16-bit wait counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- s_valid  in  1  upstream has an instruction
- s_ready  out  1  block can accept an instruction
- m_valid  out  1  result valid to the M->W bus register
- m_ready  in  1  M->W bus register accepts the result
- mem_rdE  in  1  instruction is a load
- mem_wrE  in  1  instruction is a store (mem_rdE and mem_wrE are never both 1)
- funct3E  in  3  size/sign: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned
- ALU_resultE  in  32  effective address
- src2E  in  32  store data
- mdataM  out  32  aligned, extended load data (0 for non-loads)
- bus_errM  out  1  transaction timed out or was misaligned
- mem_req  out  1  bus request
- mem_we  out  1  write enable
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_wdata  out  32  shifted store data
- mem_wmask  out  4  byte strobes
- mem_ack  in  1  transaction complete; mem_rdata valid in the same cycle
- mem_rdata  in  32  read word

Behaviour:
- States: IDLE, BUS, DONE. Outputs are decoded from the state:
  - s_ready = (state==IDLE)
  - m_valid = (state==DONE)
  - mem_req = (state==BUS)
- Accept on s_valid & s_ready. On accept, latch mem_rd, mem_wr, funct3, address and src2 into internal registers. These latched values drive all later outputs.
- Transitions:
  - IDLE -> BUS on accept when (mem_rd | mem_wr).
  - IDLE -> DONE on accept for non-memory instructions. This gives 1-cycle latency.
  - BUS -> DONE on mem_ack.
  - DONE -> IDLE on m_ready.
- Load/store latency: at least 2 cycles; exactly 2 when mem_ack arrives in the first BUS cycle.
- mem_req is held high from the first BUS cycle through the mem_ack cycle. mem_addr, mem_we, mem_wdata and mem_wmask are constant for the whole BUS state.
- mem_ack outside the BUS state is ignored.
- Store encoding, with o = addr[1:0]:
  - mem_wdata = src2 << (8*o)
  - mem_wmask for byte = 4'b0001 << o
  - mem_wmask for half = 4'b0011 << {o[1],1'b0}
  - mem_wmask for word = 4'b1111
  - For loads, mem_wmask = 0 and mem_we = 0.
- Load data: captured into mdataM on the mem_ack cycle.
  - b = mem_rdata >> (8*o)
  - byte: b[7:0], sign-extended (000) or zero-extended (100)
  - half: the halfword selected by o[1], sign-extended (001) or zero-extended (101)
  - word: mem_rdata
- Timeout (TIMEOUT != 0):
  - The counter is cleared on entry to BUS and increments each BUS cycle without mem_ack.
  - When the counter reaches TIMEOUT: deassert mem_req, go to DONE with bus_errM=1 and mdataM=0.
  - mem_ack and timeout in the same cycle: mem_ack wins.
- bus_errM and mdataM are cleared on accept of a new instruction and are held through DONE.
- DONE with m_ready=1 returns to IDLE. A new accept is possible in the next cycle; there is no same-cycle pass-through.
- Reset values: state IDLE, mem_req 0, mdataM 0, bus_errM 0, all latches 0, counter 0.
- Reset mid-BUS: mem_req drops at that clock edge and the transaction is abandoned. A late mem_ack is ignored.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined:
  - On accept, a half access with addr[0]=1 or a word access with addr[1:0]!=0 goes IDLE -> DONE directly.
  - bus_errM=1, mdataM=0, and mem_req is never asserted.
- Undefined:
  - Misalignment is never flagged; the access proceeds.
  - Half accesses ignore addr[0] and word accesses ignore addr[1:0], per the encoding rules above.

Test Plan:
- Non-memory op, s_valid=1, m_ready=1 -> m_valid 1 cycle later, mdataM=0, no mem_req; then back-to-back accepts, one every 2 cycles.
- lb at 0x80000003, mem_rdata=0x85FFFFFF, ack in 1st BUS cycle -> mem_addr=0x80000000, mdataM=0xFFFFFF85, m_valid at cycle 2; with funct3=100 -> mdataM=0x00000085.
- sh at 0x80000002, src2=0x1234ABCD, ack delayed 3 cycles -> mem_req high 4 cycles, mem_wdata=0xABCD0000, mem_wmask=1100, mem_we=1, all stable.
- m_ready held 0 for 5 cycles in DONE -> m_valid and mdataM held, s_ready=0, upstream s_valid ignored.
- TIMEOUT=4, mem_ack never arrives -> mem_req high 4 cycles, then DONE with bus_errM=1; rst asserted mid-BUS -> mem_req=0 and state IDLE next cycle.
- MISALIGN_TRAP_EN, lw at 0x80000001 -> no mem_req, DONE next cycle with bus_errM=1; without the macro -> mem_addr=0x80000000, full word returned.

Source files
------------

// File: rtl/mstage_lsu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mstage_lsu
// Purpose  : Memory-access pipeline stage. Accepts one instruction per
//            s_valid/s_ready handshake, runs at most one request/acknowledge
//            bus transaction for loads and stores, aligns and extends load
//            data, and holds the result on m_valid until m_ready.
// Ports    : clk, rst (sync, active-high)
//            s_valid/s_ready                - upstream handshake
//            m_valid/m_ready                - downstream handshake
//            mem_rdE, mem_wrE, funct3E,
//            ALU_resultE, src2E             - instruction fields from E->M
//            mdataM, bus_errM               - result to M->W
//            mem_req, mem_we, mem_addr,
//            mem_wdata, mem_wmask,
//            mem_ack, mem_rdata             - data bus
// Params   : TIMEOUT - max cycles waiting for mem_ack (0 = wait forever)
// Macros   : MISALIGN_TRAP_EN - misaligned half/word accesses skip the bus
//            and complete with bus_errM=1
// Revision : 1.0 - initial release
// ============================================================================
module mstage_lsu #(
    parameter int unsigned TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        m_valid,
    input  logic        m_ready,
    input  logic        mem_rdE,
    input  logic        mem_wrE,
    input  logic [2:0]  funct3E,
    input  logic [31:0] ALU_resultE,
    input  logic [31:0] src2E,
    output logic [31:0] mdataM,
    output logic        bus_errM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Last counter value before the timeout fires, so mem_req stays high
    // for exactly TIMEOUT cycles.
    localparam bit         c_tmo_en   = (TIMEOUT != 0);
    localparam logic [15:0] c_tmo_last = 16'(TIMEOUT - 1);

    state_t      r_state;
    logic        r_rd;
    logic        r_wr;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_src2;
    logic [15:0] r_cnt;
    logic [31:0] r_mdata;
    logic        r_err;

    logic        w_accept;
    logic        w_misal;
    logic        w_tmo;
    logic [1:0]  w_off;
    logic [31:0] w_shift;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [3:0]  w_wmask;

    assign w_accept = s_valid && (r_state == ST_IDLE);
    assign w_off    = r_addr[1:0];

`ifdef MISALIGN_TRAP_EN
    // Evaluated on the incoming fields because the decision is made at accept.
    assign w_misal = (mem_rdE || mem_wrE) &&
                     (((funct3E[1:0] == 2'b01) && ALU_resultE[0]) ||
                      ((funct3E[1:0] == 2'b10) && (ALU_resultE[1:0] != 2'b00)));
`else
    assign w_misal = 1'b0;
`endif

    assign w_tmo = c_tmo_en && (r_cnt == c_tmo_last);

    // Load alignment: byte lanes via shift, halfword picked by addr[1].
    assign w_shift = mem_rdata >> {w_off, 3'b000};
    assign w_half  = w_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        w_load = mem_rdata;
        case (r_funct3[1:0])
            2'b00:   w_load = {{24{~r_funct3[2] & w_shift[7]}}, w_shift[7:0]};
            2'b01:   w_load = {{16{~r_funct3[2] & w_half[15]}}, w_half};
            default: w_load = mem_rdata;
        endcase
    end

    always_comb begin
        w_wmask = 4'b0000;
        if (r_wr) begin
            case (r_funct3[1:0])
                2'b00:   w_wmask = 4'b0001 << w_off;
                2'b01:   w_wmask = 4'b0011 << {w_off[1], 1'b0};
                default: w_wmask = 4'b1111;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= 32'd0;
            r_src2   <= 32'd0;
            r_cnt    <= 16'd0;
            r_mdata  <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_rd     <= mem_rdE;
                        r_wr     <= mem_wrE;
                        r_funct3 <= funct3E;
                        r_addr   <= ALU_resultE;
                        r_src2   <= src2E;
                        r_cnt    <= 16'd0;
                        r_mdata  <= 32'd0;
                        r_err    <= 1'b0;
                        if (w_misal) begin
                            r_err   <= 1'b1;
                            r_state <= ST_DONE;
                        end else if (mem_rdE || mem_wrE) begin
                            r_state <= ST_BUS;
                        end else begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_BUS: begin
                    // An acknowledge in the timeout cycle still completes normally.
                    if (mem_ack) begin
                        r_mdata <= r_rd ? w_load : 32'd0;
                        r_state <= ST_DONE;
                    end else if (w_tmo) begin
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_DONE: begin
                    if (m_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s_ready   = (r_state == ST_IDLE);
    assign m_valid   = (r_state == ST_DONE);
    assign mem_req   = (r_state == ST_BUS);
    assign mem_we    = r_wr;
    assign mem_addr  = {r_addr[31:2], 2'b00};
    assign mem_wdata = r_src2 << {w_off, 3'b000};
    assign mem_wmask = w_wmask;
    assign mdataM    = r_mdata;
    assign bus_errM  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mstage_lsu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mstage_lsu
// Purpose  : Directed testbench for mstage_lsu. Each transaction is described
//            by its fields, bus-acknowledge delay and downstream stall; the
//            expected outputs for every cycle come from a transaction-level
//            model and are compared by one per-cycle checker. A few literal
//            values pin the model.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_mstage_lsu;

    localparam int TB_TIMEOUT = 4;
    localparam int NEVER      = 99;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid, s_ready, m_valid, m_ready;
    logic        mem_rdE, mem_wrE;
    logic [2:0]  funct3E;
    logic [31:0] ALU_resultE, src2E, mdataM;
    logic        bus_errM, mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    mstage_lsu #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready),
        .m_valid(m_valid), .m_ready(m_ready),
        .mem_rdE(mem_rdE), .mem_wrE(mem_wrE), .funct3E(funct3E),
        .ALU_resultE(ALU_resultE), .src2E(src2E),
        .mdataM(mdataM), .bus_errM(bus_errM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Per-cycle expectations written by the stimulus, read by the checker.
    bit          chk_en = 1'b0;
    logic        exp_s_ready, exp_m_valid, exp_req, exp_we, exp_err;
    logic [31:0] exp_addr, exp_wdata, exp_mdata;
    logic [3:0]  exp_wmask;

    // Observations from the current transaction, for literal checks.
    int          req_cycles;
    bit          got_done;
    logic [31:0] seen_addr, seen_wdata, seen_mdata;
    logic [3:0]  seen_wmask;
    logic        seen_we, seen_err;

    logic [31:0] last_mdata = 32'd0;
    logic        last_err   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("s_ready",  {31'd0, s_ready},  {31'd0, exp_s_ready});
            check("m_valid",  {31'd0, m_valid},  {31'd0, exp_m_valid});
            check("mem_req",  {31'd0, mem_req},  {31'd0, exp_req});
            check("mdataM",   mdataM,            exp_mdata);
            check("bus_errM", {31'd0, bus_errM}, {31'd0, exp_err});
            if (exp_req) begin
                check("mem_addr",  mem_addr,          exp_addr);
                check("mem_we",    {31'd0, mem_we},   {31'd0, exp_we});
                check("mem_wmask", {28'd0, mem_wmask}, {28'd0, exp_wmask});
                if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
            end
        end
    end

    // ---------------- model ----------------
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] o,
                                               input logic [31:0] w);
        logic [31:0] v;
        case (f3)
            3'b000, 3'b100: begin
                v = (w >> (8 * o)) & 32'hFF;
                if (f3 == 3'b000 && v >= 32'd128) v = v + 32'hFFFF_FF00;
            end
            3'b001, 3'b101: begin
                v = (w >> ((o >= 2) ? 16 : 0)) & 32'hFFFF;
                if (f3 == 3'b001 && v >= 32'd32768) v = v + 32'hFFFF_0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] model_wmask(input logic [2:0] f3, input logic [1:0] o);
        case (f3[1:0])
            2'b00:   return 4'(1 << o);
            2'b01:   return (o >= 2) ? 4'd12 : 4'd3;
            default: return 4'd15;
        endcase
    endfunction

    function automatic bit model_misal(input logic [2:0] f3, input logic [1:0] o);
`ifdef MISALIGN_TRAP_EN
        return ((f3 == 3'b001 || f3 == 3'b101) && o[0]) || (f3 == 3'b010 && o != 2'd0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic set_exp(input logic sr, input logic mv, input logic rq,
                           input logic [31:0] md, input logic er);
        exp_s_ready = sr; exp_m_valid = mv; exp_req = rq; exp_mdata = md; exp_err = er;
    endtask

    task automatic garbage_upstream();
        s_valid = 1'b1; mem_rdE = 1'($urandom); mem_wrE = 1'b0;
        funct3E = 3'($urandom); ALU_resultE = $urandom; src2E = $urandom;
    endtask

    // Observe at the falling edge, then move to just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        if (mem_req) begin
            req_cycles++;
            seen_addr = mem_addr; seen_wdata = mem_wdata;
            seen_wmask = mem_wmask; seen_we = mem_we;
        end
        if (m_valid && !got_done) begin
            got_done = 1'b1; seen_mdata = mdataM; seen_err = bus_errM;
        end
        @(posedge clk);
        #1;
    endtask

    // One full instruction: accept, optional bus phase, DONE with 'hold' stall cycles.
    task automatic run(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] src2,
                       input logic [31:0] rdata, input int dly, input int hold,
                       input bit rst_mid);
        logic [1:0]  o;
        bit          mem, misal, tout;
        int          nbus;
        logic [31:0] res;
        o = addr[1:0];
        mem = rd || wr;
        misal = mem && model_misal(f3, o);
        tout = mem && !misal && dly >= TB_TIMEOUT;
        nbus = tout ? TB_TIMEOUT : dly + 1;
        req_cycles = 0; got_done = 1'b0;

        // Accept cycle; a stray acknowledge here must be ignored.
        s_valid = 1'b1; mem_rdE = rd; mem_wrE = wr; funct3E = f3;
        ALU_resultE = addr; src2E = src2; m_ready = 1'b0;
        mem_ack = 1'b1; mem_rdata = $urandom;
        set_exp(1'b1, 1'b0, 1'b0, last_mdata, last_err);
        tick();

        if (mem && !misal) begin
            exp_addr = {addr[31:2], 2'b00}; exp_we = wr;
            exp_wmask = wr ? model_wmask(f3, o) : 4'd0;
            exp_wdata = src2 << (8 * o);
            for (int i = 0; i < nbus; i++) begin
                garbage_upstream();
                mem_ack = !tout && (i == dly);
                mem_rdata = mem_ack ? rdata : $urandom;
                set_exp(1'b0, 1'b0, 1'b1, 32'd0, 1'b0);
                if (rst_mid && i == 1) rst = 1'b1;
                tick();
                if (rst_mid && i == 1) begin
                    rst = 1'b0; s_valid = 1'b0; mem_ack = 1'b1; mem_rdata = $urandom;
                    last_mdata = 32'd0; last_err = 1'b0;
                    set_exp(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
                    tick();
                    mem_ack = 1'b0;
                    return;
                end
            end
        end

        res = (misal || tout || !rd) ? 32'd0 : model_load(f3, o, rdata);
        for (int j = 0; j <= hold; j++) begin
            garbage_upstream();
            m_ready = (j == hold);
            mem_ack = 1'b1; mem_rdata = $urandom;
            set_exp(1'b0, 1'b1, 1'b0, res, misal || tout);
            tick();
        end
        last_mdata = res; last_err = misal || tout;
        s_valid = 1'b0; m_ready = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b0; m_ready = 1'($urandom); mem_ack = 1'($urandom);
            set_exp(1'b1, 1'b0, 1'b0, last_mdata, last_err);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; mem_rdE = 1'b0; mem_wrE = 1'b0;
        funct3E = 3'd0; ALU_resultE = 32'd0; src2E = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        set_exp(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        idle(1);

        // Non-memory ops back-to-back.
        for (int k = 0; k < 3; k++) begin
            run(1'b0, 1'b0, 3'b010, $urandom, $urandom, 32'd0, 0, 0, 1'b0);
            check("nonmem_req_cycles", req_cycles, 0);
        end

        // lb / lbu with acknowledge in the first bus cycle.
        run(1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'd0, 32'h85FF_FFFF, 0, 0, 1'b0);
        check("lb_mdata", seen_mdata, 32'hFFFF_FF85);
        check("lb_addr", seen_addr, 32'h8000_0000);
        check("lb_req_cycles", req_cycles, 1);
        run(1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'd0, 32'h85FF_FFFF, 0, 0, 1'b0);
        check("lbu_mdata", seen_mdata, 32'h0000_0085);

        // Non-memory op after a load clears the result.
        run(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 0, 0, 1'b0);
        check("nonmem_mdata", seen_mdata, 32'd0);

        // sh with delayed acknowledge (3 wait cycles, ack in the timeout cycle).
        run(1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 32'd0, 3, 0, 1'b0);
        check("sh_req_cycles", req_cycles, 4);
        check("sh_wdata", seen_wdata, 32'hABCD_0000);
        check("sh_wmask", {28'd0, seen_wmask}, 32'hC);
        check("sh_we", {31'd0, seen_we}, 32'd1);
        check("sh_err", {31'd0, seen_err}, 32'd0);

        // Every byte/half lane for loads and stores.
        for (int o = 0; o < 4; o++) begin
            run(1'b1, 1'b0, 3'b000, 32'h1000_0000 + o, 32'd0, 32'h8C7B_6A59, o % 2, 0, 1'b0);
            run(1'b1, 1'b0, 3'b101, 32'h1000_0000 + (o & 2), 32'd0, 32'h8C7B_F6A5, 1, 1, 1'b0);
            run(1'b1, 1'b0, 3'b001, 32'h1000_0000 + (o & 2), 32'd0, 32'h8C7B_F6A5, 0, 0, 1'b0);
            run(1'b0, 1'b1, 3'b000, 32'h2000_0000 + o, 32'h0000_00E7, 32'd0, 2, 0, 1'b0);
        end
        run(1'b1, 1'b0, 3'b001, 32'h1000_0000, 32'd0, 32'h0000_8001, 0, 0, 1'b0);
        check("lh_mdata", seen_mdata, 32'hFFFF_8001);
        run(1'b0, 1'b1, 3'b010, 32'h3000_0004, 32'hCAFE_F00D, 32'd0, 1, 0, 1'b0);
        check("sw_wmask", {28'd0, seen_wmask}, 32'hF);

        // Downstream stall for 5 cycles with upstream pushing garbage.
        run(1'b1, 1'b0, 3'b010, 32'h4000_0008, 32'd0, 32'h1357_9BDF, 0, 5, 1'b0);
        check("stall_mdata", seen_mdata, 32'h1357_9BDF);

        // Timeout: no acknowledge ever arrives.
        run(1'b1, 1'b0, 3'b010, 32'h5000_0000, 32'd0, 32'd0, NEVER, 1, 1'b0);
        check("tmo_req_cycles", req_cycles, 4);
        check("tmo_err", {31'd0, seen_err}, 32'd1);
        check("tmo_mdata", seen_mdata, 32'd0);

        // Reset in the middle of a bus transaction; late acknowledge ignored.
        run(1'b1, 1'b0, 3'b010, 32'h6000_0000, 32'd0, 32'd0, NEVER, 0, 1'b1);
        idle(2);

        // Misaligned word and halfword loads.
        run(1'b1, 1'b0, 3'b010, 32'h8000_0001, 32'd0, 32'hDEAD_BEEF, 0, 0, 1'b0);
`ifdef MISALIGN_TRAP_EN
        check("misal_lw_req_cycles", req_cycles, 0);
        check("misal_lw_err", {31'd0, seen_err}, 32'd1);
        check("misal_lw_mdata", seen_mdata, 32'd0);
`else
        check("misal_lw_addr", seen_addr, 32'h8000_0000);
        check("misal_lw_mdata", seen_mdata, 32'hDEAD_BEEF);
        check("misal_lw_err", {31'd0, seen_err}, 32'd0);
`endif
        run(1'b1, 1'b0, 3'b101, 32'h8000_0003, 32'd0, 32'hBEEF_1234, 0, 0, 1'b0);
`ifdef MISALIGN_TRAP_EN
        check("misal_lhu_err", {31'd0, seen_err}, 32'd1);
`else
        check("misal_lhu_mdata", seen_mdata, 32'h0000_BEEF);
`endif
        run(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 0, 0, 1'b0);
        idle(2);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
